// File: rtl/lcd_char_writer_if.sv
// lcd_char_writer_if: character stream in, HD44780 4-bit bus and status out
interface lcd_char_writer_if;
  logic [7:0] char;
  logic       valid_i;
  logic       init_done;
  logic       busy;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_DB;
  modport master (output char, valid_i, input init_done, busy, LCD_E, LCD_RS, LCD_RW, LCD_DB);
  modport slave  (input char, valid_i, output init_done, busy, LCD_E, LCD_RS, LCD_RW, LCD_DB);
endinterface

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: double-buffered 32-char screen writer driving a 16x2 HD44780 over its 4-bit bus
module lcd_char_writer #(
  parameter int T_PWRON = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_E     = 12
) (
  input logic CLK,
  input logic RST,
  lcd_char_writer_if.slave bus
);
  typedef enum logic [2:0] {S_PWRON, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2} state_t;
  typedef enum logic [1:0] {P_SETUP, P_EHI, P_HOLD, P_WAIT} phase_t;
  localparam logic [7:0] INIT_SEQ [8] = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h28, 8'h06, 8'h0C, 8'h01};
  localparam logic [31:0] TE_N = 32'(T_E - 1);
  state_t      state_q, state_d, next_s;
  phase_t      ph_q, ph_d;
  logic [31:0] cnt_q, cnt_d, wait_n;
  logic [3:0]  step_q, step_d, db_q, db_d, nib;
  logic [4:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  val;
  logic [7:0]  mem_q [2][32];
  logic lo_q, lo_d, e_q, e_d, rs_q, rs_d, busy_q, busy_d, init_done_q, init_done_d;
  logic bank_q, bank_d, pending_q, pending_d;
  logic active, rs_i, is_byte, last, done, swap, burst_end;
  always_comb begin
    active = !(state_q inside {S_PWRON, S_IDLE});
    rs_i = state_q inside {S_LINE1, S_LINE2};
    val = state_q == S_INIT ? INIT_SEQ[step_q[2:0]] :
          state_q == S_ADDR1 ? 8'h80 :
          state_q == S_ADDR2 ? 8'hC0 : mem_q[bank_q][{state_q == S_LINE2, step_q}];
    // the first four init writes are lone nibbles, everything else is a full byte
    is_byte = !(state_q == S_INIT && !step_q[2]);
    nib = (is_byte && !lo_q) ? val[7:4] : val[3:0];
    wait_n = (state_q == S_INIT && step_q == 4'd0) ? 32'(T_INIT1) :
             (state_q == S_INIT && step_q == 4'd1) ? 32'(T_INIT2) :
             (!rs_i && val == 8'h01) ? 32'(T_CLR) : 32'(T_CMD);
    last = state_q == S_INIT ? step_q == 4'd7 : rs_i ? step_q == 4'd15 : 1'b1;
    next_s = state_q == S_ADDR1 ? S_LINE1 : state_q == S_LINE1 ? S_ADDR2 :
             state_q == S_ADDR2 ? S_LINE2 : S_IDLE;
    done = cnt_q == 32'd0;
    burst_end = bus.valid_i && wr_idx_q == 5'd31;
    swap = state_q == S_IDLE && pending_q && init_done_q;
    wr_idx_d = bus.valid_i ? wr_idx_q + 5'd1 : 5'd0;
    pending_d = burst_end || (pending_q && !swap);
    bank_d = bank_q ^ swap;
    state_d = state_q;
    ph_d = ph_q;
    cnt_d = done ? cnt_q : cnt_q - 32'd1;
    step_d = step_q;
    lo_d = lo_q;
    init_done_d = init_done_q;
    if ((state_q == S_PWRON && done) || swap) begin
      state_d = swap ? S_ADDR1 : S_INIT;
      ph_d = P_SETUP;
      cnt_d = TE_N;
      step_d = 4'd0;
      lo_d = 1'b0;
    end else if (active && done) begin
      cnt_d = TE_N;
      case (ph_q)
        P_SETUP: ph_d = P_EHI;
        P_EHI: begin
          ph_d = (is_byte && !lo_q) ? P_SETUP : P_HOLD;
          lo_d = is_byte;
        end
        P_HOLD: begin
          ph_d = P_WAIT;
          cnt_d = wait_n - 32'd1;
        end
        default: begin
          ph_d = P_SETUP;
          lo_d = 1'b0;
          step_d = last ? 4'd0 : step_q + 4'd1;
          state_d = last ? next_s : state_q;
          init_done_d = init_done_q || (last && state_q == S_INIT);
        end
      endcase
    end
    e_d = active && ph_q == P_EHI;
    rs_d = active ? rs_i : rs_q;
    db_d = active ? nib : db_q;
    busy_d = state_d inside {S_ADDR1, S_LINE1, S_ADDR2, S_LINE2};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_PWRON;
      ph_q <= P_SETUP;
      cnt_q <= 32'(T_PWRON - 1);
      step_q <= '0;
      lo_q <= 1'b0;
      e_q <= 1'b0;
      rs_q <= 1'b0;
      db_q <= '0;
      busy_q <= 1'b0;
      init_done_q <= 1'b0;
      bank_q <= 1'b0;
      pending_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      lo_q <= lo_d;
      e_q <= e_d;
      rs_q <= rs_d;
      db_q <= db_d;
      busy_q <= busy_d;
      init_done_q <= init_done_d;
      bank_q <= bank_d;
      pending_q <= pending_d;
      wr_idx_q <= wr_idx_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (bus.valid_i) mem_q[~bank_q][wr_idx_q] <= bus.char;
  end
  assign bus.LCD_E = e_q;
  assign bus.LCD_RS = rs_q;
  assign bus.LCD_RW = 1'b0;
  assign bus.LCD_DB = db_q;
  assign bus.busy = busy_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: random screens checked against a nibble-level model of the HD44780 bus
module tb_lcd_char_writer;
  localparam int T_PWRON = 20, T_INIT1 = 10, T_INIT2 = 5, T_CMD = 4, T_CLR = 8, T_E = 2;
  typedef struct {logic [4:0] nib; int w; int t;} pulse_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lcd_char_writer_if bus();
  lcd_char_writer #(.T_PWRON(T_PWRON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
                    .T_CLR(T_CLR), .T_E(T_E)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  pulse_t pq[$];
  logic [4:0] exp_q[$];
  int exp_gap[$];
  logic [7:0] scr[32], scr2[32];
  int n_cmp = 0, n_bad = 0, cyc = 0, hi_w = 0, hi_t = 0;
  logic [4:0] hi_nib;
  bit busy_seen = 0;
  // every E pulse becomes one {RS,DB} record with its width and rise cycle
  always @(negedge clk) begin
    cyc++;
    if (bus.LCD_E === 1'b1) begin
      if (hi_w == 0) hi_t = cyc;
      hi_w++;
      hi_nib = {bus.LCD_RS, bus.LCD_DB};
    end else if (hi_w > 0) begin
      pq.push_back('{hi_nib, hi_w, hi_t});
      hi_w = 0;
    end
    if (bus.busy === 1'b1) busy_seen = 1;
  end
  function automatic void exp_nib(input logic rs, input logic [3:0] n, input int gap);
    exp_q.push_back({rs, n});
    exp_gap.push_back(gap);
  endfunction
  function automatic void exp_byte(input logic rs, input logic [7:0] b, input int w);
    exp_nib(rs, b[7:4], 2 * T_E);
    exp_nib(rs, b[3:0], 3 * T_E + w);
  endfunction
  function automatic void exp_init();
    exp_q.delete();
    exp_gap.delete();
    exp_nib(1'b0, 4'h3, 3 * T_E + T_INIT1);
    exp_nib(1'b0, 4'h3, 3 * T_E + T_INIT2);
    exp_nib(1'b0, 4'h3, 3 * T_E + T_CMD);
    exp_nib(1'b0, 4'h2, 3 * T_E + T_CMD);
    exp_byte(1'b0, 8'h28, T_CMD);
    exp_byte(1'b0, 8'h06, T_CMD);
    exp_byte(1'b0, 8'h0C, T_CMD);
    exp_byte(1'b0, 8'h01, T_CLR);
    exp_gap[exp_gap.size() - 1] = -1;
  endfunction
  function automatic void exp_screen(input logic [7:0] s[32]);
    exp_byte(1'b0, 8'h80, T_CMD);
    for (int i = 0; i < 16; i++) exp_byte(1'b1, s[i], T_CMD);
    exp_byte(1'b0, 8'hC0, T_CMD);
    for (int i = 16; i < 32; i++) exp_byte(1'b1, s[i], T_CMD);
    exp_gap[exp_gap.size() - 1] = -1;
  endfunction
  function automatic void rand_scr();
    for (int i = 0; i < 32; i++) scr[i] = 8'($urandom_range(32, 126));
  endfunction
  task automatic send(input logic [7:0] s[32], input int n);
    for (int i = 0; i < n; i++) begin
      bus.char = s[i];
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
  endtask
  task automatic wait_for(input int sel, input int n, input int lim, output bit ok);
    ok = 0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk);
      ok = sel == 0 ? bus.init_done === 1'b1 : sel == 1 ? bus.busy === 1'b1 :
           sel == 2 ? bus.busy === 1'b0 : pq.size() >= n;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DB} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_lcd: got E,RS,RW,DB=%b, want 0000000", {bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DB});
    end
    n_cmp++;
    if ({bus.busy, bus.init_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_status: got busy,init_done=%b, want 00", {bus.busy, bus.init_done});
    end
  endtask
  task automatic test_init();
    bit ok;
    int c = 0;
    rst = 1'b0;
    pq.delete();
    busy_seen = 0;
    while (bus.LCD_E !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
    n_cmp++;
    if (c < T_PWRON || c >= 1000) begin
      n_bad++;
      $display("FAIL init_pwron: got first E after %0d cycles, want >= %0d", c, T_PWRON);
    end
    wait_for(0, 0, 2000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL init_done: got 0 after 2000 cycles, want 1"); end
    repeat (30) @(negedge clk);
    exp_init();
    n_cmp++;
    if (pq.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL init_count: got %0d nibbles, want %0d", pq.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < pq.size()) begin
      n_cmp++;
      if (pq[i].nib !== exp_q[i] || pq[i].w != T_E ||
          (exp_gap[i] >= 0 && i + 1 < pq.size() && pq[i + 1].t - pq[i].t != exp_gap[i])) begin
        n_bad++;
        $display("FAIL init_nib %0d: got rs,db=%h w=%0d gap=%0d, want %h w=%0d gap=%0d", i, pq[i].nib,
                 pq[i].w, i + 1 < pq.size() ? pq[i + 1].t - pq[i].t : -1, exp_q[i], T_E, exp_gap[i]);
      end
    end
    n_cmp++;
    if (busy_seen || bus.init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL init_status: got busy_seen=%0d init_done=%b, want 0 and 1", busy_seen, bus.init_done);
    end
  endtask
  task automatic test_hello();
    bit ok1, ok2;
    string s = "HELLO FPGA WELCOME TO IKEDA LAB!";
    for (int i = 0; i < 32; i++) scr[i] = s[i];
    pq.delete();
    send(scr, 32);
    wait_for(1, 0, 100, ok1);
    wait_for(2, 0, 2000, ok2);
    n_cmp++;
    if (!ok1 || !ok2) begin n_bad++; $display("FAIL hello_busy: got rise=%0d fall=%0d, want 1 1", ok1, ok2); end
    repeat (20) @(negedge clk);
    exp_q.delete();
    exp_gap.delete();
    exp_screen(scr);
    n_cmp++;
    if (pq.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL hello_count: got %0d nibbles, want %0d", pq.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < pq.size()) begin
      n_cmp++;
      if (pq[i].nib !== exp_q[i] || pq[i].w != T_E ||
          (exp_gap[i] >= 0 && i + 1 < pq.size() && pq[i + 1].t - pq[i].t != exp_gap[i])) begin
        n_bad++;
        $display("FAIL hello_nib %0d: got rs,db=%h w=%0d gap=%0d, want %h w=%0d gap=%0d", i, pq[i].nib,
                 pq[i].w, i + 1 < pq.size() ? pq[i + 1].t - pq[i].t : -1, exp_q[i], T_E, exp_gap[i]);
      end
    end
    n_cmp++;
    if (bus.init_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hello_status: got init_done=%b busy=%b, want 1 0", bus.init_done, bus.busy);
    end
  endtask
  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    rand_scr();
    for (int i = 0; i < 32; i++) scr2[i] = 8'h41;
    pq.delete();
    send(scr, 32);
    wait_for(1, 0, 100, ok1);
    repeat (40) @(negedge clk);
    send(scr2, 32);
    wait_for(3, 136, 3000, ok2);
    wait_for(2, 0, 200, ok3);
    n_cmp++;
    if (!ok1 || !ok2 || !ok3) begin
      n_bad++;
      $display("FAIL b2b_progress: got busy=%0d pulses=%0d idle=%0d, want 1 1 1", ok1, ok2, ok3);
    end
    repeat (30) @(negedge clk);
    exp_q.delete();
    exp_gap.delete();
    exp_screen(scr);
    exp_screen(scr2);
    n_cmp++;
    if (pq.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d nibbles, want %0d", pq.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < pq.size()) begin
      n_cmp++;
      if (pq[i].nib !== exp_q[i] || pq[i].w != T_E ||
          (exp_gap[i] >= 0 && i + 1 < pq.size() && pq[i + 1].t - pq[i].t != exp_gap[i])) begin
        n_bad++;
        $display("FAIL b2b_nib %0d: got rs,db=%h w=%0d, want %h w=%0d", i, pq[i].nib, pq[i].w, exp_q[i], T_E);
      end
    end
  endtask
  task automatic test_partial();
    bit ok1, ok2;
    rand_scr();
    for (int i = 0; i < 32; i++) scr2[i] = 8'h42;
    pq.delete();
    send(scr, 10);
    @(posedge clk); #1;
    send(scr2, 32);
    wait_for(1, 0, 100, ok1);
    wait_for(2, 0, 2000, ok2);
    n_cmp++;
    if (!ok1 || !ok2) begin n_bad++; $display("FAIL partial_busy: got rise=%0d fall=%0d, want 1 1", ok1, ok2); end
    repeat (60) @(negedge clk);
    exp_q.delete();
    exp_gap.delete();
    exp_screen(scr2);
    n_cmp++;
    if (pq.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL partial_count: got %0d nibbles, want %0d", pq.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < pq.size()) begin
      n_cmp++;
      if (pq[i].nib !== exp_q[i]) begin
        n_bad++;
        $display("FAIL partial_nib %0d: got rs,db=%h, want %h", i, pq[i].nib, exp_q[i]);
      end
    end
  endtask
  task automatic test_burst_in_init();
    bit ok1, ok2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pq.delete();
    repeat (3) @(negedge clk);
    rand_scr();
    send(scr, 32);
    wait_for(0, 0, 2000, ok1);
    exp_init();
    n_cmp++;
    if (!ok1 || pq.size() != exp_q.size() || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL early_e: got init_done=%0d nibbles=%0d busy=%b, want 1 %0d 0", ok1, pq.size(), exp_q.size(), bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL refresh_start: got busy=%b, want 1", bus.busy); end
    wait_for(2, 0, 2000, ok2);
    repeat (20) @(negedge clk);
    exp_screen(scr);
    n_cmp++;
    if (!ok2 || pq.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL init_burst_count: got %0d nibbles, want %0d", pq.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < pq.size()) begin
      n_cmp++;
      if (pq[i].nib !== exp_q[i] || pq[i].w != T_E) begin
        n_bad++;
        $display("FAIL init_burst_nib %0d: got rs,db=%h w=%0d, want %h w=%0d", i, pq[i].nib, pq[i].w, exp_q[i], T_E);
      end
    end
  endtask
  task automatic test_mid_reset();
    bit ok1, ok2, ok3;
    int c = 0;
    rand_scr();
    pq.delete();
    send(scr, 32);
    wait_for(1, 0, 100, ok1);
    wait_for(3, 5, 500, ok2);
    while (bus.LCD_E !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    n_cmp++;
    if (!ok1 || !ok2 || c >= 100) begin
      n_bad++;
      $display("FAIL midrst_reach: got busy=%0d pulses=%0d e_wait=%0d, want 1 1 <100", ok1, ok2, c);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.LCD_E, bus.busy, bus.init_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_abort: got E,busy,init_done=%b, want 000", {bus.LCD_E, bus.busy, bus.init_done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pq.delete();
    busy_seen = 0;
    c = 0;
    while (bus.LCD_E !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
    n_cmp++;
    if (c < T_PWRON || c >= 1000) begin
      n_bad++;
      $display("FAIL midrst_pwron: got first E after %0d cycles, want >= %0d", c, T_PWRON);
    end
    wait_for(0, 0, 2000, ok3);
    repeat (60) @(negedge clk);
    exp_init();
    n_cmp++;
    if (!ok3 || pq.size() != exp_q.size() || busy_seen) begin
      n_bad++;
      $display("FAIL midrst_replay: got init_done=%0d nibbles=%0d busy_seen=%0d, want 1 %0d 0", ok3, pq.size(), busy_seen, exp_q.size());
    end
    foreach (exp_q[i]) if (i < pq.size()) begin
      n_cmp++;
      if (pq[i].nib !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midrst_nib %0d: got rs,db=%h, want %h", i, pq[i].nib, exp_q[i]);
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.char = 8'h00;
    bus.valid_i = 1'b0;
    test_reset();
    test_init();
    test_hello();
    test_back_to_back();
    test_partial();
    test_burst_in_init();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
